eth_tx_sched: RTL

//  Schedules the 10BASE-T transmitter. Arbitrates frame requests from the audio

---
 rtl/eth_pkg.sv | 36 +++
 rtl/eth_tick_timer.sv | 38 +++
 rtl/eth_tx_sched.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the 10BASE-T transmit scheduler.
// State encoding, frame_sel values, default tick counts, tie-break helper.
package eth_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_WAIT_ACK = 3'd2;
  localparam logic [2:0] S_BUSY     = 3'd3;
  localparam logic [2:0] S_IFG      = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = S_IDLE,
    ST_START    = S_START,
    ST_WAIT_ACK = S_WAIT_ACK,
    ST_BUSY     = S_BUSY,
    ST_IFG      = S_IFG
  } state_t;

  localparam logic FRM_AUDIO = 1'b0;
  localparam logic FRM_CTRL  = 1'b1;

  localparam int DEF_IFG_TICKS   = 96;
  localparam int DEF_NLP_PERIOD  = 160000;
  localparam int DEF_ACK_TIMEOUT = 4;
  localparam int DEF_LED_HOLD    = 500000;

  // pref names the source that wins when both request.
  function automatic logic rr_pick_ctrl(
    input logic ra,
    input logic rc,
    input logic pref
  );
    return rc & (~ra | (pref == FRM_CTRL));
  endfunction

endpackage

// File: rtl/eth_tick_timer.sv
// Loadable saturating down-counter advanced only on ticks; done when zero.
// Ports: clk, rst, tick (enable), load, load_val[W], done.
module eth_tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      if (load) begin
        cnt_d = load_val;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/eth_tx_sched.sv
// 10BASE-T transmit scheduler: round-robin grant, start strobe, IFG,
// ack timeout, activity LED, optional link pulses (macro ETH_NLP_EN).
// In : clk, rst, eth_clk_en, req_audio, req_ctrl, tx_busy
// Out: grant_audio, grant_ctrl, frame_sel, tx_start, nlp, tx_led, tx_err
module eth_tx_sched
  import eth_pkg::*;
#(
  parameter int IFG_TICKS   = DEF_IFG_TICKS,
  parameter int NLP_PERIOD  = DEF_NLP_PERIOD,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int LED_HOLD    = DEF_LED_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic eth_clk_en,
  input  logic req_audio,
  input  logic req_ctrl,
  output logic grant_audio,
  output logic grant_ctrl,
  output logic frame_sel,
  output logic tx_start,
  input  logic tx_busy,
  output logic nlp,
  output logic tx_led,
  output logic tx_err
);

  localparam int IFG_W = $clog2(IFG_TICKS + 1);
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam int LED_W = $clog2(LED_HOLD + 1);

  state_t state_q, state_d;
  logic   ga_q, ga_d;
  logic   gc_q, gc_d;
  logic   sel_q, sel_d;
  logic   start_q, start_d;
  logic   nlp_q, nlp_d;
  logic   led_q, led_d;
  logic   err_q, err_d;
  logic   rr_q, rr_d;
  logic   ifg_ld;
  logic   ifg_done;
  logic   ack_done;
  logic   led_done;
  logic   nlp_due;
  logic   pick;

  // IFG->IDLE costs one tick, so the gap timer is loaded two short
  // to put the next possible start exactly IFG_TICKS after the fall.
  eth_tick_timer #(.W(IFG_W)) u_ifg (
    .clk      (clk),
    .rst      (rst),
    .tick     (eth_clk_en),
    .load     (ifg_ld),
    .load_val (IFG_W'(IFG_TICKS - 2)),
    .done     (ifg_done)
  );

  // Loaded one short: the ack window closes on the
  // ACK_TIMEOUT-th tick after the start strobe.
  eth_tick_timer #(.W(ACK_W)) u_ack (
    .clk      (clk),
    .rst      (rst),
    .tick     (eth_clk_en),
    .load     (start_d),
    .load_val (ACK_W'(ACK_TIMEOUT - 1)),
    .done     (ack_done)
  );

  eth_tick_timer #(.W(LED_W)) u_led (
    .clk      (clk),
    .rst      (rst),
    .tick     (eth_clk_en),
    .load     (start_d),
    .load_val (LED_W'(LED_HOLD - 1)),
    .done     (led_done)
  );

`ifdef ETH_NLP_EN
  localparam int NLP_W = $clog2(NLP_PERIOD + 1);

  logic idle_run;
  logic idle_ld;
  logic idle_done;

  // Idle time only accrues while the line is quiet.
  assign idle_run = (state_q == ST_IDLE) || (state_q == ST_IFG);
  assign idle_ld  = start_d | nlp_d;

  eth_tick_timer #(.W(NLP_W)) u_nlp (
    .clk      (clk),
    .rst      (rst),
    .tick     (eth_clk_en & idle_run),
    .load     (idle_ld),
    .load_val (NLP_W'(NLP_PERIOD - 1)),
    .done     (idle_done)
  );

  assign nlp_due = idle_done & (state_q == ST_IDLE);
`else
  assign nlp_due = 1'b0;
`endif

  assign pick = rr_pick_ctrl(req_audio, req_ctrl, rr_q);

  always_comb begin
    state_d = state_q;
    ga_d    = ga_q;
    gc_d    = gc_q;
    sel_d   = sel_q;
    start_d = start_q;
    nlp_d   = nlp_q;
    led_d   = led_q;
    err_d   = err_q;
    rr_d    = rr_q;
    ifg_ld  = 1'b0;
    if (eth_clk_en) begin
      ga_d    = 1'b0;
      gc_d    = 1'b0;
      start_d = 1'b0;
      nlp_d   = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (nlp_due) begin
            nlp_d   = 1'b1;
            ifg_ld  = 1'b1;
            state_d = ST_IFG;
          end else if (req_audio | req_ctrl) begin
            ga_d    = ~pick;
            gc_d    = pick;
            sel_d   = pick ? FRM_CTRL : FRM_AUDIO;
            rr_d    = pick ? FRM_AUDIO : FRM_CTRL;
            start_d = 1'b1;
            state_d = ST_START;
          end
        end
        ST_START: begin
          state_d = ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (tx_busy) begin
            state_d = ST_BUSY;
          end else if (ack_done) begin
            err_d   = 1'b1;
            ifg_ld  = 1'b1;
            state_d = ST_IFG;
          end
        end
        ST_BUSY: begin
          if (!tx_busy) begin
            ifg_ld  = 1'b1;
            state_d = ST_IFG;
          end
        end
        ST_IFG: begin
          if (ifg_done) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
      if (start_d) begin
        led_d = 1'b1;
      end else if (led_done) begin
        led_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ga_q    <= 1'b0;
      gc_q    <= 1'b0;
      sel_q   <= FRM_AUDIO;
      start_q <= 1'b0;
      nlp_q   <= 1'b0;
      led_q   <= 1'b0;
      err_q   <= 1'b0;
      rr_q    <= FRM_AUDIO;
    end else begin
      state_q <= state_d;
      ga_q    <= ga_d;
      gc_q    <= gc_d;
      sel_q   <= sel_d;
      start_q <= start_d;
      nlp_q   <= nlp_d;
      led_q   <= led_d;
      err_q   <= err_d;
      rr_q    <= rr_d;
    end
  end

  assign grant_audio = ga_q;
  assign grant_ctrl  = gc_q;
  assign frame_sel   = sel_q;
  assign tx_start    = start_q;
  assign nlp         = nlp_q;
  assign tx_led      = led_q;
  assign tx_err      = err_q;

endmodule
